// File: rtl/uart_tx_sched_if.sv
// rtl/uart_tx_sched_if.sv - UART register bus between the TX scheduler and the UART slave port
interface uart_tx_sched_if;
  logic [3:0]  m_adr_o;
  logic [31:0] m_dat_o;
  logic [3:0]  m_sel_o;
  logic        m_we_o;
  logic        m_stb_o;
  logic        m_ack_i;
  logic [31:0] m_dat_i;

  modport master (
    output m_adr_o, m_dat_o, m_sel_o, m_we_o, m_stb_o,
    input  m_ack_i, m_dat_i
  );

  modport slave (
    input  m_adr_o, m_dat_o, m_sel_o, m_we_o, m_stb_o,
    output m_ack_i, m_dat_i
  );
endinterface

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin two-requester scheduler driving one UART transmitter
// Optional poll timeout with sticky err_o when UART_SCHED_TIMEOUT_EN is defined.
module uart_tx_sched #(
  parameter logic [31:0] DIVIDER = 32'h00000018,
  parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
  input  logic       clk,
  input  logic       rst_i,
  input  logic       req0_valid_i,
  input  logic [7:0] req0_data_i,
  output logic       req0_ready_o,
  input  logic       req1_valid_i,
  input  logic [7:0] req1_data_i,
  output logic       req1_ready_o,
  output logic       busy_o,
  output logic       grant_o,
  output logic       err_o,
  uart_tx_sched_if.master bus
);
  localparam logic [3:0] ADR_TX     = 4'h0;
  localparam logic [3:0] ADR_STATUS = 4'h8;
  localparam logic [3:0] ADR_DIV    = 4'hC;

  typedef enum logic [2:0] {INIT, IDLE, WRITE, POLL, CAPTURE} state_t;
  state_t state;

  logic pick1;
  logic timed_out;
  logic unused_rx;

  // On a tie the requester that did not win last time is served.
  assign pick1 = req1_valid_i && (!req0_valid_i || !grant_o);

  assign bus.m_sel_o = 4'hF;
  assign unused_rx   = ^bus.m_dat_i[31:1];

`ifdef UART_SCHED_TIMEOUT_EN
  logic [15:0] poll_cnt;
  assign timed_out = (poll_cnt >= TIMEOUT);
`else
  logic [15:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
  assign timed_out      = 1'b0;
  assign err_o          = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state        <= INIT;
      bus.m_stb_o  <= 1'b0;
      bus.m_we_o   <= 1'b0;
      bus.m_adr_o  <= 4'h0;
      bus.m_dat_o  <= 32'h0;
      req0_ready_o <= 1'b0;
      req1_ready_o <= 1'b0;
      busy_o       <= 1'b1;
      grant_o      <= 1'b1;
`ifdef UART_SCHED_TIMEOUT_EN
      poll_cnt     <= 16'h0;
      err_o        <= 1'b0;
`endif
    end else begin
      req0_ready_o <= 1'b0;
      req1_ready_o <= 1'b0;
      case (state)
        INIT: begin
          bus.m_stb_o <= 1'b1;
          bus.m_we_o  <= 1'b1;
          bus.m_adr_o <= ADR_DIV;
          bus.m_dat_o <= DIVIDER;
          if (bus.m_stb_o && bus.m_ack_i) begin
            bus.m_stb_o <= 1'b0;
            bus.m_we_o  <= 1'b0;
            busy_o      <= 1'b0;
            state       <= IDLE;
          end
        end
        IDLE: begin
          if (req0_valid_i || req1_valid_i) begin
            grant_o      <= pick1;
            req0_ready_o <= !pick1;
            req1_ready_o <= pick1;
            bus.m_stb_o  <= 1'b1;
            bus.m_we_o   <= 1'b1;
            bus.m_adr_o  <= ADR_TX;
            bus.m_dat_o  <= {24'h0, pick1 ? req1_data_i : req0_data_i};
            busy_o       <= 1'b1;
`ifdef UART_SCHED_TIMEOUT_EN
            poll_cnt     <= 16'h0;
`endif
            state        <= WRITE;
          end
        end
        WRITE: begin
          if (bus.m_ack_i) begin
            bus.m_we_o  <= 1'b0;
            bus.m_adr_o <= ADR_STATUS;
            state       <= POLL;
          end
        end
        POLL: begin
          if (bus.m_ack_i) begin
            bus.m_stb_o <= 1'b0;
`ifdef UART_SCHED_TIMEOUT_EN
            poll_cnt    <= poll_cnt + 16'd1;
`endif
            state       <= CAPTURE;
          end
        end
        CAPTURE: begin
          // Read data lags the acknowledged read by one cycle, so it is sampled here.
          if (bus.m_dat_i[0] && !timed_out) begin
            bus.m_stb_o <= 1'b1;
            state       <= POLL;
          end else begin
`ifdef UART_SCHED_TIMEOUT_EN
            if (bus.m_dat_i[0]) err_o <= 1'b1;
`endif
            busy_o <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - directed bench for uart_tx_sched against a behavioural UART model
module tb_uart_tx_sched;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_i;
  logic       req0_valid_i, req1_valid_i;
  logic [7:0] req0_data_i, req1_data_i;
  logic       req0_ready_o, req1_ready_o;
  logic       busy_o, grant_o, err_o;

  int checks = 0;
  int errors = 0;

  uart_tx_sched_if bus ();

  uart_tx_sched #(.DIVIDER(32'h00000018), .TIMEOUT(16'd4)) dut (
    .clk          (clk),
    .rst_i        (rst_i),
    .req0_valid_i (req0_valid_i),
    .req0_data_i  (req0_data_i),
    .req0_ready_o (req0_ready_o),
    .req1_valid_i (req1_valid_i),
    .req1_data_i  (req1_data_i),
    .req1_ready_o (req1_ready_o),
    .busy_o       (busy_o),
    .grant_o      (grant_o),
    .err_o        (err_o),
    .bus          (bus)
  );

  // UART model: same-cycle ack, status busy for busy_polls reads after each TX write.
  logic [36:0] txn_q[$];
  logic [7:0]  wr_q[$];
  logic [31:0] rdata_r;
  int          uart_busy = 0;
  int          busy_polls = 1;
  int          overlap = 0;
  bit          stuck = 1'b0;

  assign bus.m_ack_i = bus.m_stb_o;
  assign bus.m_dat_i = rdata_r;

  always @(posedge clk) begin
    if (rst_i) begin
      uart_busy = 0;
      rdata_r <= 32'h0;
    end else if (bus.m_stb_o && bus.m_ack_i) begin
      txn_q.push_back({bus.m_we_o, bus.m_adr_o, bus.m_dat_o});
      if (bus.m_we_o && bus.m_adr_o == 4'h0) begin
        if (uart_busy != 0) overlap++;
        uart_busy = busy_polls;
      end else if (!bus.m_we_o && bus.m_adr_o == 4'h8) begin
        rdata_r <= {31'h0, stuck || (uart_busy != 0)};
        if (uart_busy > 0) uart_busy--;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int count_reads(input int from);
    int n = 0;
    for (int i = from; i < txn_q.size(); i++)
      if (txn_q[i][36:32] == 5'b0_1000) n++;
    return n;
  endfunction

  task automatic collect_writes(input int from);
    wr_q.delete();
    for (int i = from; i < txn_q.size(); i++)
      if (txn_q[i][36:32] == 5'b1_0000) wr_q.push_back(txn_q[i][7:0]);
  endtask

  initial begin
    int n0, n1, idle, cyc, base;
    rst_i = 1'b1;
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    req0_data_i = 8'h00; req1_data_i = 8'h00;
    repeat (2) @(negedge clk);

    check("rst_stb", bus.m_stb_o, 1'b0);
    check("rst_we", bus.m_we_o, 1'b0);
    check("rst_adr", bus.m_adr_o, 4'h0);
    check("rst_dat", bus.m_dat_o, 32'h0);
    check("rst_sel", bus.m_sel_o, 4'hF);
    check("rst_ready0", req0_ready_o, 1'b0);
    check("rst_ready1", req1_ready_o, 1'b0);
    check("rst_busy", busy_o, 1'b1);
    check("rst_grant", grant_o, 1'b1);
    check("rst_err", err_o, 1'b0);

    // Divider write on the first cycle after reset release.
    base = txn_q.size();
    rst_i = 1'b0;
    @(negedge clk);
    check("init_stb", bus.m_stb_o, 1'b1);
    check("init_we", bus.m_we_o, 1'b1);
    check("init_adr", bus.m_adr_o, 4'hC);
    check("init_dat", bus.m_dat_o, 32'h00000018);
    repeat (4) @(negedge clk);
    check("init_busy_fall", busy_o, 1'b0);
    check("init_txn_count", txn_q.size() - base, 1);
    check("init_txn", txn_q[base], {1'b1, 4'hC, 32'h00000018});

    // Both requesters held valid: grants alternate starting with requester 0.
    base = txn_q.size();
    busy_polls = 1;
    req0_data_i = 8'hAA; req1_data_i = 8'h55;
    req0_valid_i = 1'b1; req1_valid_i = 1'b1;
    n0 = 0; n1 = 0; cyc = 0;
    while ((req0_valid_i || req1_valid_i || busy_o) && cyc < 500) begin
      @(negedge clk); cyc++;
      if (req0_ready_o) begin n0++; if (n0 == 4) req0_valid_i = 1'b0; end
      if (req1_ready_o) begin n1++; if (n1 == 4) req1_valid_i = 1'b0; end
    end
    check("rr_in_time", cyc < 500, 1'b1);
    check("rr_ready0", n0, 4);
    check("rr_ready1", n1, 4);
    collect_writes(base);
    check("rr_count", wr_q.size(), 8);
    for (int k = 0; k < 8; k++)
      check($sformatf("rr_byte%0d", k), wr_q[k], (k % 2 == 0) ? 8'hAA : 8'h55);
    check("rr_overlap", overlap, 0);

    // Single byte from requester 0 with the UART busy for three polls.
    base = txn_q.size();
    busy_polls = 3;
    req0_data_i = 8'h41; req0_valid_i = 1'b1;
    @(negedge clk);
    check("a0_ready", req0_ready_o, 1'b1);
    check("a0_grant", grant_o, 1'b0);
    check("a0_wr_stb", bus.m_stb_o, 1'b1);
    check("a0_wr_adr", bus.m_adr_o, 4'h0);
    check("a0_wr_dat", bus.m_dat_o, 32'h00000041);
    req0_valid_i = 1'b0;
    n0 = 1; cyc = 0;
    while (busy_o && cyc < 100) begin
      @(negedge clk); cyc++;
      if (req0_ready_o) n0++;
    end
    check("a0_cycles", cyc, 9);
    check("a0_ready_once", n0, 1);
    check("a0_txn_count", txn_q.size() - base, 5);
    check("a0_txn_write", txn_q[base], {1'b1, 4'h0, 32'h00000041});
    check("a0_reads", count_reads(base), 4);

    // Only requester 1 valid: four back-to-back grants, one idle cycle between bytes.
    base = txn_q.size();
    busy_polls = 1;
    req1_data_i = 8'h10; req1_valid_i = 1'b1;
    n0 = 0; n1 = 0; idle = 0; cyc = 0;
    while ((req1_valid_i || busy_o) && cyc < 300) begin
      @(negedge clk); cyc++;
      if (req0_ready_o) n0++;
      if (req1_ready_o) begin
        n1++;
        req1_data_i = req1_data_i + 8'd1;
        if (n1 == 4) req1_valid_i = 1'b0;
      end else if (n1 >= 1 && n1 < 4 && !busy_o) idle++;
    end
    check("r1_ready1", n1, 4);
    check("r1_ready0", n0, 0);
    check("r1_idle_gaps", idle, 3);
    check("r1_grant", grant_o, 1'b1);
    collect_writes(base);
    check("r1_count", wr_q.size(), 4);
    for (int k = 0; k < 4; k++)
      check($sformatf("r1_byte%0d", k), wr_q[k], 8'h10 + k);
    check("r1_overlap", overlap, 0);

    // Reset while polling: divider rewritten, pending byte not resent.
    busy_polls = 5;
    req0_data_i = 8'h77; req0_valid_i = 1'b1;
    @(negedge clk);
    req0_valid_i = 1'b0;
    cyc = 0;
    while (!(bus.m_stb_o && !bus.m_we_o && bus.m_adr_o == 4'h8) && cyc < 20) begin
      @(negedge clk); cyc++;
    end
    check("rp_in_poll", cyc < 20, 1'b1);
    rst_i = 1'b1;
    @(negedge clk);
    check("rp_rst_stb", bus.m_stb_o, 1'b0);
    check("rp_rst_busy", busy_o, 1'b1);
    check("rp_rst_grant", grant_o, 1'b1);
    rst_i = 1'b0;
    base = txn_q.size();
    @(negedge clk);
    check("rp_div_stb", bus.m_stb_o, 1'b1);
    check("rp_div_adr", bus.m_adr_o, 4'hC);
    check("rp_div_dat", bus.m_dat_o, 32'h00000018);
    repeat (20) @(negedge clk);
    check("rp_txn_count", txn_q.size() - base, 1);
    check("rp_busy", busy_o, 1'b0);

    // Status stuck busy.
    stuck = 1'b1;
    busy_polls = 1;
    base = txn_q.size();
    req1_data_i = 8'h99; req1_valid_i = 1'b1;
    @(negedge clk);
    req1_valid_i = 1'b0;
    check("to_ready1", req1_ready_o, 1'b1);
`ifdef UART_SCHED_TIMEOUT_EN
    cyc = 0;
    while (busy_o && cyc < 200) begin
      @(negedge clk); cyc++;
    end
    check("to_reads", count_reads(base), 4);
    check("to_err", err_o, 1'b1);
    check("to_busy", busy_o, 1'b0);
`else
    repeat (1100) @(negedge clk);
    check("to_busy", busy_o, 1'b1);
    check("to_err", err_o, 1'b0);
    check("to_reads", count_reads(base) >= 500, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Transmit scheduler that shares the single UART transmitter between two byte requesters. After reset it programs the UART baud divider once, then round-robin arbitrates requests, writes each granted byte to the UART TX data register and polls the UART status register until the transmitter is idle before serving the next byte. It sits between the UART's bus slave port and two producers: the CPU debug path on requester 0 and the hardware event logger on requester 1.

## Interface
- DIVIDER, 32'h00000018, value written to the UART divider register after reset.
- TIMEOUT, 16'hFFFF, maximum status polls per byte; used only when UART_SCHED_TIMEOUT_EN is defined.
- clk  in  1  system clock; all logic on its rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- req0_valid_i  in  1  requester 0 has a byte.
- req0_data_i  in  8  requester 0 byte.
- req0_ready_o  out  1  one-cycle accept pulse to requester 0.
- req1_valid_i, req1_data_i, req1_ready_o: same as requester 0, for requester 1.
- m_adr_o  out  4  UART byte address: 0x0 TX data, 0x8 status, 0xC divider.
- m_dat_o  out  32  write data.
- m_sel_o  out  4  byte selects; always 4'hF.
- m_we_o  out  1  write enable.
- m_stb_o  out  1  bus strobe.
- m_ack_i  in  1  UART acknowledge.
- m_dat_i  in  32  UART read data; valid on the cycle after the acknowledged read.
- busy_o  out  1  high in every state except IDLE.
- grant_o  out  1  requester number of the most recent grant.
- err_o  out  1  sticky poll-timeout flag; constant 0 without the macro.

## Operation
- States: INIT, IDLE, WRITE, POLL, CAPTURE.
- INIT: drive adr 0xC, we=1, dat=DIVIDER, stb=1; on ack go to IDLE.
- IDLE: stb=0. When at least one valid is high, grant per round-robin, latch the byte, pulse that requester's ready_o, update grant_o, and go to WRITE.
- Round-robin: if only one valid is high, that requester wins. If both are high, the requester not equal to grant_o wins.
- WRITE: adr 0x0, we=1, dat={24'h0, byte}, stb=1; on ack go to POLL. The UART sets status bit 0 (TX busy) on this write.
- POLL: adr 0x8, we=0, stb=1; on ack go to CAPTURE.
- CAPTURE: stb=0; sample m_dat_i. If bit 0 is 1, return to POLL. If bit 0 is 0, go to IDLE. Bit 1 (RX available) is ignored.
- Bus rule: stb, adr, we and dat are held stable until ack_i is high. Exactly one cycle of stb is issued when ack is combinational.
- Only one byte is in flight. A requester holds valid and data until it sees its ready pulse.
- A valid that drops before its grant is dropped with no side effects.
- Reset mid-transfer: outputs return to reset values and the block re-enters INIT, so the divider is rewritten.

## Timing
- Reset values: m_stb_o=0, m_we_o=0, m_adr_o=0, m_dat_o=0, m_sel_o=4'hF, req*_ready_o=0, busy_o=1, grant_o=1, err_o=0, state=INIT.
- grant_o=1 at reset, so requester 0 wins the first tie.
- The INIT write is on the first cycle after rst_i deasserts.
- IDLE accept to WRITE stb: 1 cycle.
- With same-cycle ack, each poll iteration (POLL then CAPTURE) takes 2 cycles.
- Minimum byte-to-byte spacing is 1 IDLE cycle after the CAPTURE that finds the transmitter idle.
- The ready pulse occurs in the same cycle as the transition from IDLE.
- Simultaneous valid on both requesters alternates grants: 0, 1, 0, 1, ...

## Configuration
- UART_SCHED_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to WRITE and increments on every POLL ack.
  - If CAPTURE sees bit 0 still set after TIMEOUT polls, set err_o (sticky until reset) and go to IDLE.
- UART_SCHED_TIMEOUT_EN undefined:
  - The counter is absent, err_o is tied to 0, and polling continues indefinitely.

## Test plan
- Reset release with UART model: exactly one write of 32'h00000018 to adr 0xC occurs, then busy_o falls.
- req0 sends 8'h41, UART busy for 3 polls: sequence is write 0x41 to adr 0x0, then 4 reads of adr 0x8; ready0 pulses once; grant_o=0.
- req0 and req1 held valid with 8'hAA / 8'h55 for four bytes each: TX writes are AA, 55, AA, 55, ...; no write overlaps a busy status.
- Only req1 valid, four bytes: all four are granted to req1 back-to-back, with no idle grant lost to requester 0.
- rst_i asserted during POLL: the cycle after rst_i falls is the divider write; the pending byte is not resent.
- With UART_SCHED_TIMEOUT_EN, TIMEOUT=4 and status stuck at 1: exactly 4 polls, then err_o=1 and busy_o=0. Without the macro, polling continues past 1000 cycles and err_o stays 0.
